// File: rtl/hsid_pkg.sv
// rtl/hsid_pkg.sv - shared widths, limits and FSM states for the hsid MSE scheduler
package hsid_pkg;

  localparam int unsigned HSID_WORD_WIDTH    = 32;
  localparam int unsigned HSID_DATA_WIDTH    = 16;
  localparam int unsigned HSID_BANDS_WIDTH   = 8;
  localparam int unsigned HSID_LIBRARY_WIDTH = 8;

  // Smallest band count the MSE datapath can process.
  localparam int unsigned HSID_MIN_BANDS = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } hsid_sched_state_t;

endpackage

// File: rtl/hsid_min_tracker.sv
// rtl/hsid_min_tracker.sv - running minimum over MSE results with overflow exclusion
// Ports: clk/rst; clear re-arms (value all-ones, ref 0, invalid); take accepts one
// result (value, result_ref, mse_of, acc_of); min_value/min_ref/min_valid hold the best so far.
module hsid_min_tracker #(
  parameter int VALUE_WIDTH = 32,
  parameter int REF_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   take,
  input  logic [VALUE_WIDTH-1:0] value,
  input  logic [REF_WIDTH-1:0]   result_ref,
  input  logic                   mse_of,
  input  logic                   acc_of,
  output logic [VALUE_WIDTH-1:0] min_value,
  output logic [REF_WIDTH-1:0]   min_ref,
  output logic                   min_valid
);

  logic usable;
  logic better;

  // Overflowed results are counted by the scheduler but never compete.
  assign usable = take && !mse_of && !acc_of;
  // Strict less-than: results arrive in reference order, so a tie keeps the lower reference.
  assign better = !min_valid || (value < min_value);

  always_ff @(posedge clk) begin
    if (rst) begin
      min_value <= '0;
      min_ref   <= '0;
      min_valid <= 1'b0;
    end else if (clear) begin
      min_value <= '1;
      min_ref   <= '0;
      min_valid <= 1'b0;
    end else if (usable && better) begin
      min_value <= value;
      min_ref   <= result_ref;
      min_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/hsid_mse_sched.sv
// rtl/hsid_mse_sched.sv - streams pixel and library vectors into the MSE unit and picks the minimum
// Ports: start/abort control; hsp_bands/hsp_library run configuration; pix_rd_*/lib_rd_*
// word memory reads (1-cycle latency); band_pack_* and mse_clear drive the MSE unit;
// mse_* result stream in; busy/done/error status; min_mse_* classification result.
module hsid_mse_sched
  import hsid_pkg::*;
#(
  parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
  parameter int DATA_WIDTH        = HSID_DATA_WIDTH,
  parameter int HSP_BANDS_WIDTH   = HSID_BANDS_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = HSID_LIBRARY_WIDTH
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic                                        abort,
  input  logic [HSP_BANDS_WIDTH-1:0]                  hsp_bands,
  input  logic [HSP_LIBRARY_WIDTH-1:0]                hsp_library,
  output logic                                        pix_rd_en,
  output logic [HSP_BANDS_WIDTH-2:0]                  pix_rd_addr,
  input  logic [WORD_WIDTH-1:0]                       pix_rd_data,
  output logic                                        lib_rd_en,
  output logic [HSP_LIBRARY_WIDTH+HSP_BANDS_WIDTH-2:0] lib_rd_addr,
  input  logic [WORD_WIDTH-1:0]                       lib_rd_data,
  output logic                                        mse_clear,
  output logic                                        band_pack_start,
  output logic                                        band_pack_last,
  output logic                                        band_pack_valid,
  output logic [WORD_WIDTH-1:0]                       band_pack_a,
  output logic [WORD_WIDTH-1:0]                       band_pack_b,
  output logic [HSP_LIBRARY_WIDTH-1:0]                vctr_ref,
  output logic [HSP_BANDS_WIDTH-1:0]                  mse_hsp_bands,
  input  logic [WORD_WIDTH-1:0]                       mse_value,
  input  logic [HSP_LIBRARY_WIDTH-1:0]                mse_ref,
  input  logic                                        mse_valid,
  input  logic                                        mse_of,
  input  logic                                        acc_of,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        error,
  output logic [WORD_WIDTH-1:0]                       min_mse_value,
  output logic [HSP_LIBRARY_WIDTH-1:0]                min_mse_ref,
  output logic                                        min_valid
);

  localparam int PAW = HSP_BANDS_WIDTH - 1;
  localparam logic [HSP_BANDS_WIDTH-1:0]   MIN_BANDS = HSP_BANDS_WIDTH'(HSID_MIN_BANDS);
  localparam logic [PAW-1:0]               ONE_P     = {{(PAW-1){1'b0}}, 1'b1};
  localparam logic [HSP_LIBRARY_WIDTH-1:0] ONE_L     = {{(HSP_LIBRARY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [HSP_LIBRARY_WIDTH:0]   ONE_C     = {{HSP_LIBRARY_WIDTH{1'b0}}, 1'b1};

  hsid_sched_state_t state, state_nxt;

  logic [HSP_BANDS_WIDTH-1:0]   bands_q;
  logic [HSP_LIBRARY_WIDTH-1:0] lib_q;
  logic [HSP_LIBRARY_WIDTH-1:0] vctr_idx;
  logic [PAW-1:0]               word_idx;
  logic [PAW-1:0]               last_word;
  logic [HSP_LIBRARY_WIDTH:0]   res_cnt;
  logic                         odd_last_q;
  logic                         idle_like, start_go, abort_go;
  logic                         rd_en, final_rd, res_take;

  // Index of the last word of a vector: ceil(bands/2)-1 without widening.
  assign last_word = bands_q[0] ? bands_q[HSP_BANDS_WIDTH-1:1]
                                : bands_q[HSP_BANDS_WIDTH-1:1] - ONE_P;

  assign busy      = (state == CLEAR) || (state == STREAM) || (state == DRAIN);
  assign done      = (state == DONE);
  assign error     = (state == ERROR);
  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERROR);
  assign start_go  = start && !abort && idle_like;
  assign abort_go  = abort && busy;

  // An abort suppresses the read issued in the same cycle so nothing reaches the MSE unit.
  assign rd_en    = (state == STREAM) && !abort;
  assign final_rd = rd_en && (word_idx == last_word) && (vctr_idx == lib_q - ONE_L);
  assign res_take = mse_valid && ((state == STREAM) || (state == DRAIN));

  assign pix_rd_en     = rd_en;
  assign lib_rd_en     = rd_en;
  assign pix_rd_addr   = word_idx;
  assign lib_rd_addr   = {vctr_idx, word_idx};
  assign mse_hsp_bands = bands_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start_go) begin
          if ((hsp_bands < MIN_BANDS) || (hsp_library == '0)) state_nxt = ERROR;
          else                                                state_nxt = CLEAR;
        end
      end
      CLEAR:   state_nxt = abort ? IDLE : STREAM;
      STREAM: begin
        if (abort)         state_nxt = IDLE;
        else if (final_rd) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort)                          state_nxt = IDLE;
        else if (res_cnt == {1'b0, lib_q})  state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bands_q         <= '0;
      lib_q           <= '0;
      word_idx        <= '0;
      vctr_idx        <= '0;
      res_cnt         <= '0;
      mse_clear       <= 1'b0;
      band_pack_valid <= 1'b0;
      band_pack_start <= 1'b0;
      band_pack_last  <= 1'b0;
      vctr_ref        <= '0;
      odd_last_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      // Registered so the pulse lines up with the CLEAR cycle or the cycle after an abort.
      mse_clear <= (state_nxt == CLEAR) || abort_go;

      if (start_go) begin
        bands_q <= hsp_bands;
        lib_q   <= hsp_library;
      end

      if (state == CLEAR) begin
        word_idx <= '0;
        vctr_idx <= '0;
      end else if (rd_en) begin
        if (word_idx == last_word) begin
          word_idx <= '0;
          vctr_idx <= vctr_idx + ONE_L;
        end else begin
          word_idx <= word_idx + ONE_P;
        end
      end

      if (state == CLEAR)  res_cnt <= '0;
      else if (res_take)   res_cnt <= res_cnt + ONE_C;

      // Control travels one cycle behind the read so it meets the returned data.
      band_pack_valid <= rd_en;
      band_pack_start <= rd_en && (word_idx == '0);
      band_pack_last  <= rd_en && (word_idx == last_word);
      odd_last_q      <= rd_en && (word_idx == last_word) && bands_q[0];
      if (rd_en) vctr_ref <= vctr_idx;
    end
  end

  // With an odd band count the final word carries one real band in its upper half.
  always_comb begin
    band_pack_a = '0;
    band_pack_b = '0;
    if (band_pack_valid) begin
      band_pack_a = pix_rd_data;
      band_pack_b = lib_rd_data;
      if (odd_last_q) begin
        band_pack_a[DATA_WIDTH-1:0] = '0;
        band_pack_b[DATA_WIDTH-1:0] = '0;
      end
    end
  end

  hsid_min_tracker #(
    .VALUE_WIDTH (WORD_WIDTH),
    .REF_WIDTH   (HSP_LIBRARY_WIDTH)
  ) u_min_tracker (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == CLEAR),
    .take       (res_take),
    .value      (mse_value),
    .result_ref (mse_ref),
    .mse_of     (mse_of),
    .acc_of     (acc_of),
    .min_value  (min_mse_value),
    .min_ref    (min_mse_ref),
    .min_valid  (min_valid)
  );

endmodule

// File: tb/tb_hsid_mse_sched.sv
// tb/tb_hsid_mse_sched.sv - self-checking bench for hsid_mse_sched
module tb_hsid_mse_sched;

  localparam int LAT = 3;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        l;
    logic [7:0]  vr;
    int          cyc;
  } pack_t;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0]  hsp_bands = '0, hsp_library = '0;
  logic        pix_rd_en, lib_rd_en;
  logic [6:0]  pix_rd_addr;
  logic [14:0] lib_rd_addr;
  logic [31:0] pix_rd_data = '0, lib_rd_data = '0;
  logic        mse_clear, band_pack_start, band_pack_last, band_pack_valid;
  logic [31:0] band_pack_a, band_pack_b;
  logic [7:0]  vctr_ref, mse_hsp_bands;
  logic [31:0] mse_value = '0;
  logic [7:0]  mse_ref = '0;
  logic        mse_valid = 1'b0, mse_of = 1'b0, acc_of = 1'b0;
  logic        busy, done, error, min_valid;
  logic [31:0] min_mse_value;
  logic [7:0]  min_mse_ref;

  int n_chk = 0, n_pass = 0, cyc = 0;

  logic [31:0] pix_mem [0:127];
  logic [31:0] lib_mem [0:32767];
  logic [31:0] res_val [0:255];
  bit          res_of  [0:255];
  bit          res_acc [0:255];

  pack_t packs[$];
  int    pix_addrs[$], lib_addrs[$];
  int    mq_due[$], mq_ref[$];

  hsid_mse_sched dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .hsp_bands(hsp_bands), .hsp_library(hsp_library),
    .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
    .lib_rd_en(lib_rd_en), .lib_rd_addr(lib_rd_addr), .lib_rd_data(lib_rd_data),
    .mse_clear(mse_clear), .band_pack_start(band_pack_start), .band_pack_last(band_pack_last),
    .band_pack_valid(band_pack_valid), .band_pack_a(band_pack_a), .band_pack_b(band_pack_b),
    .vctr_ref(vctr_ref), .mse_hsp_bands(mse_hsp_bands),
    .mse_value(mse_value), .mse_ref(mse_ref), .mse_valid(mse_valid), .mse_of(mse_of), .acc_of(acc_of),
    .busy(busy), .done(done), .error(error),
    .min_mse_value(min_mse_value), .min_mse_ref(min_mse_ref), .min_valid(min_valid)
  );

  always #5 clk = ~clk;

  // Word memories with one cycle of read latency.
  always @(posedge clk) begin
    if (pix_rd_en) pix_rd_data <= pix_mem[pix_rd_addr];
    if (lib_rd_en) lib_rd_data <= lib_mem[lib_rd_addr];
  end

  // Observer plus MSE unit model: one result per vector, LAT cycles after its last pack.
  always @(negedge clk) begin : mon
    pack_t p;
    int    r;
    cyc = cyc + 1;
    if (pix_rd_en) pix_addrs.push_back(int'(pix_rd_addr));
    if (lib_rd_en) lib_addrs.push_back(int'(lib_rd_addr));
    if (band_pack_valid) begin
      p.a = band_pack_a; p.b = band_pack_b; p.s = band_pack_start;
      p.l = band_pack_last; p.vr = vctr_ref; p.cyc = cyc;
      packs.push_back(p);
      if (band_pack_last) begin
        mq_due.push_back(cyc + LAT);
        mq_ref.push_back(int'(vctr_ref));
      end
    end
    mse_valid <= 1'b0;
    mse_of    <= 1'b0;
    acc_of    <= 1'b0;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      r = mq_ref.pop_front();
      void'(mq_due.pop_front());
      mse_valid <= 1'b1;
      mse_value <= res_val[r];
      mse_ref   <= r[7:0];
      mse_of    <= res_of[r];
      acc_of    <= res_acc[r];
    end
  end

  task automatic clear_results();
    for (int i = 0; i < 256; i++) begin
      res_val[i] = '0; res_of[i] = 1'b0; res_acc[i] = 1'b0;
    end
  endtask

  task automatic fill_mem(input int b, input int l);
    for (int w = 0; w < 128; w++) pix_mem[w] = $urandom;
    for (int v = 0; v < l; v++)
      for (int w = 0; w < (b + 1) / 2; w++) lib_mem[15'(v * 128 + w)] = $urandom;
  endtask

  task automatic do_run(input int b, input int l, output int waited);
    packs.delete(); pix_addrs.delete(); lib_addrs.delete();
    hsp_bands = b[7:0]; hsp_library = l[7:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!(done || error) && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // Expected pack stream built from the memories: every vector in order, every word in order.
  function automatic int stream_errors(input int b, input int l);
    int wpv = (b + 1) / 2;
    int n = 0;
    int k = 0;
    logic [31:0] ea, eb;
    if (packs.size() != wpv * l) return 1000 + packs.size();
    for (int v = 0; v < l; v++) begin
      for (int w = 0; w < wpv; w++) begin
        ea = pix_mem[w];
        eb = lib_mem[15'(v * 128 + w)];
        if ((b % 2 == 1) && (w == wpv - 1)) begin ea[15:0] = '0; eb[15:0] = '0; end
        if (packs[k].a !== ea || packs[k].b !== eb || packs[k].s !== (w == 0) ||
            packs[k].l !== (w == wpv - 1) || packs[k].vr !== v[7:0]) n++;
        if (lib_addrs[k] != v * 128 + w || pix_addrs[k] != w) n++;
        if (packs[k].cyc != packs[0].cyc + k) n++;
        k++;
      end
    end
    return n;
  endfunction

  // Smallest non-overflowed value first, then the lowest reference holding it.
  function automatic void model_min(input int l, output logic [31:0] mv, output logic [7:0] mr,
                                    output bit ok);
    bit found = 1'b0;
    ok = 1'b0; mv = '1; mr = '0;
    for (int i = 0; i < l; i++)
      if (!res_of[i] && !res_acc[i]) begin
        if (!ok || res_val[i] < mv) mv = res_val[i];
        ok = 1'b1;
      end
    for (int i = 0; i < l; i++)
      if (ok && !found && !res_of[i] && !res_acc[i] && res_val[i] == mv) begin
        mr = i[7:0]; found = 1'b1;
      end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if ({busy, done, error, mse_clear, band_pack_valid, pix_rd_en, lib_rd_en, min_valid} !== 8'h00)
      $display("FAIL reset_flags got %b exp 00000000", {busy, done, error, mse_clear, band_pack_valid, pix_rd_en, lib_rd_en, min_valid}); else n_pass++;
    n_chk++; if (min_mse_value !== 32'd0 || min_mse_ref !== 8'd0)
      $display("FAIL reset_min got %h/%0d exp 0/0", min_mse_value, min_mse_ref); else n_pass++;
    n_chk++; if (band_pack_a !== 32'd0 || band_pack_b !== 32'd0 || mse_hsp_bands !== 8'd0 || vctr_ref !== 8'd0)
      $display("FAIL reset_data got a=%h b=%h bands=%0d ref=%0d exp 0", band_pack_a, band_pack_b, mse_hsp_bands, vctr_ref); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_idle busy got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_basic();
    int w;
    clear_results();
    res_val[0] = 40; res_val[1] = 12; res_val[2] = 30;
    fill_mem(6, 3);
    do_run(6, 3, w);
    n_chk++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL basic_done got done=%b busy=%b exp 1/0", done, busy); else n_pass++;
    n_chk++; if (packs.size() != 9) $display("FAIL basic_count got %0d exp 9", packs.size()); else n_pass++;
    n_chk++; if (stream_errors(6, 3) != 0) $display("FAIL basic_stream got %0d errors exp 0", stream_errors(6, 3)); else n_pass++;
    n_chk++; if (min_mse_value !== 32'd12 || min_mse_ref !== 8'd1 || min_valid !== 1'b1)
      $display("FAIL basic_min got %0d ref %0d v %b exp 12 ref 1 v 1", min_mse_value, min_mse_ref, min_valid); else n_pass++;
    n_chk++; if (mse_hsp_bands !== 8'd6) $display("FAIL basic_bands got %0d exp 6", mse_hsp_bands); else n_pass++;
  endtask

  task automatic test_odd();
    int w;
    int exp_a[8] = '{0, 1, 2, 3, 128, 129, 130, 131};
    int bad = 0;
    clear_results();
    res_val[0] = 7; res_val[1] = 9;
    fill_mem(7, 2);
    do_run(7, 2, w);
    for (int i = 0; i < 8; i++) if (i >= lib_addrs.size() || lib_addrs[i] != exp_a[i]) bad++;
    n_chk++; if (bad != 0 || lib_addrs.size() != 8)
      $display("FAIL odd_lib_addr got %0d wrong of %0d exp 0 of 8", bad, lib_addrs.size()); else n_pass++;
    n_chk++; if (packs.size() != 8 || packs[3].a[15:0] !== 16'd0 || packs[7].b[15:0] !== 16'd0)
      $display("FAIL odd_mask got n=%0d a3=%h b7=%h exp low 0000", packs.size(), packs[3].a, packs[7].b); else n_pass++;
    n_chk++; if (stream_errors(7, 2) != 0) $display("FAIL odd_stream got %0d errors exp 0", stream_errors(7, 2)); else n_pass++;
    n_chk++; if (done !== 1'b1 || min_mse_value !== 32'd7 || min_mse_ref !== 8'd0)
      $display("FAIL odd_min got done=%b %0d ref %0d exp 1 7 ref 0", done, min_mse_value, min_mse_ref); else n_pass++;
  endtask

  task automatic test_tie_overflow();
    int w;
    clear_results();
    res_val[0] = 20; res_val[1] = 20; res_val[2] = 5; res_of[2] = 1'b1;
    fill_mem(5, 3);
    do_run(5, 3, w);
    n_chk++; if (min_mse_value !== 32'd20 || min_mse_ref !== 8'd0 || min_valid !== 1'b1)
      $display("FAIL tie_min got %0d ref %0d v %b exp 20 ref 0 v 1", min_mse_value, min_mse_ref, min_valid); else n_pass++;
    clear_results();
    res_val[0] = 3; res_of[0] = 1'b1; res_val[1] = 4; res_acc[1] = 1'b1;
    do_run(5, 2, w);
    n_chk++; if (done !== 1'b1 || min_valid !== 1'b0)
      $display("FAIL allof_valid got done=%b v=%b exp 1/0", done, min_valid); else n_pass++;
    n_chk++; if (min_mse_value !== 32'hFFFF_FFFF || min_mse_ref !== 8'd0)
      $display("FAIL allof_value got %h ref %0d exp ffffffff ref 0", min_mse_value, min_mse_ref); else n_pass++;
  endtask

  task automatic test_error();
    int w;
    clear_results();
    do_run(4, 3, w);
    repeat (3) @(negedge clk);
    n_chk++; if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL err_bands got e=%b b=%b d=%b exp 1/0/0", error, busy, done); else n_pass++;
    n_chk++; if (pix_addrs.size() + lib_addrs.size() != 0)
      $display("FAIL err_bands_reads got %0d exp 0", pix_addrs.size() + lib_addrs.size()); else n_pass++;
    do_run(9, 0, w);
    repeat (3) @(negedge clk);
    n_chk++; if (error !== 1'b1 || busy !== 1'b0 || pix_addrs.size() + lib_addrs.size() != 0)
      $display("FAIL err_lib got e=%b b=%b reads=%0d exp 1/0/0", error, busy, pix_addrs.size() + lib_addrs.size()); else n_pass++;
    res_val[0] = 77;
    fill_mem(5, 1);
    do_run(5, 1, w);
    n_chk++; if (error !== 1'b0 || done !== 1'b1 || min_mse_value !== 32'd77)
      $display("FAIL err_recover got e=%b d=%b min=%0d exp 0/1/77", error, done, min_mse_value); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int g;
    clear_results();
    res_val[0] = 9; res_val[1] = 3;
    fill_mem(6, 2);
    packs.delete(); pix_addrs.delete(); lib_addrs.delete();
    hsp_bands = 8'd6; hsp_library = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    hsp_bands = 8'd10; hsp_library = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!done && g < 200) begin @(negedge clk); g++; end
    n_chk++; if (done !== 1'b1 || stream_errors(6, 2) != 0 || mse_hsp_bands !== 8'd6)
      $display("FAIL busy_start got done=%b errs=%0d bands=%0d exp 1/0/6", done, stream_errors(6, 2), mse_hsp_bands); else n_pass++;
    n_chk++; if (min_mse_value !== 32'd3 || min_mse_ref !== 8'd1)
      $display("FAIL busy_start_min got %0d ref %0d exp 3 ref 1", min_mse_value, min_mse_ref); else n_pass++;
    abort = 1'b1; start = 1'b1; hsp_bands = 8'd6; hsp_library = 8'd2;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    n_chk++; if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL abort_start got done=%b busy=%b exp 1/0", done, busy); else n_pass++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk++; if (done !== 1'b0 || busy !== 1'b1 || mse_clear !== 1'b1)
      $display("FAIL restart got done=%b busy=%b clr=%b exp 0/1/1", done, busy, mse_clear); else n_pass++;
    g = 0;
    while (!done && g < 200) begin @(negedge clk); g++; end
    n_chk++; if (done !== 1'b1 || min_mse_value !== 32'd3)
      $display("FAIL restart_done got done=%b min=%0d exp 1/3", done, min_mse_value); else n_pass++;
  endtask

  task automatic test_abort();
    int g;
    int w;
    clear_results();
    fill_mem(8, 4);
    hsp_bands = 8'd8; hsp_library = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!pix_rd_en && g < 20) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
    n_chk++; if (pix_rd_en !== 1'b1 || busy !== 1'b1)
      $display("FAIL abort_stream got rd=%b busy=%b exp 1/1", pix_rd_en, busy); else n_pass++;
    #1 abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_chk++; if (mse_clear !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || band_pack_valid !== 1'b0)
      $display("FAIL abort_pulse got clr=%b busy=%b done=%b bpv=%b exp 1/0/0/0", mse_clear, busy, done, band_pack_valid); else n_pass++;
    @(negedge clk);
    n_chk++; if (mse_clear !== 1'b0) $display("FAIL abort_pulse_len got %b exp 0", mse_clear); else n_pass++;
    g = 0;
    repeat (15) begin @(negedge clk); if (done || busy || pix_rd_en) g++; end
    n_chk++; if (g != 0) $display("FAIL abort_idle got %0d active cycles exp 0", g); else n_pass++;
    res_val[0] = 50; res_val[1] = 8;
    fill_mem(6, 2);
    do_run(6, 2, w);
    n_chk++; if (done !== 1'b1 || stream_errors(6, 2) != 0 || min_mse_value !== 32'd8 || min_mse_ref !== 8'd1)
      $display("FAIL abort_rerun got done=%b errs=%0d min=%0d ref=%0d exp 1/0/8/1", done, stream_errors(6, 2), min_mse_value, min_mse_ref); else n_pass++;
  endtask

  task automatic test_reset_drain();
    int g;
    clear_results();
    res_val[0] = 40; res_val[1] = 12; res_val[2] = 30;
    fill_mem(6, 3);
    hsp_bands = 8'd6; hsp_library = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!pix_rd_en && g < 20) begin @(negedge clk); g++; end
    while (pix_rd_en && g < 40) begin @(negedge clk); g++; end
    n_chk++; if (busy !== 1'b1 || min_valid !== 1'b1)
      $display("FAIL drain_reached got busy=%b v=%b exp 1/1", busy, min_valid); else n_pass++;
    #1 rst = 1'b1;
    @(negedge clk);
    n_chk++; if ({busy, done, error, mse_clear, band_pack_valid, min_valid} !== 6'd0 ||
                 min_mse_value !== 32'd0 || vctr_ref !== 8'd0 || mse_hsp_bands !== 8'd0)
      $display("FAIL drain_rst got flags=%b min=%h ref=%0d bands=%0d exp 0", {busy, done, error, mse_clear, band_pack_valid, min_valid}, min_mse_value, vctr_ref, mse_hsp_bands); else n_pass++;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    n_chk++; if (min_valid !== 1'b0 || done !== 1'b0 || min_mse_value !== 32'd0)
      $display("FAIL late_result got v=%b done=%b min=%h exp 0/0/0", min_valid, done, min_mse_value); else n_pass++;
  endtask

  task automatic test_random();
    int w, b, l;
    logic [31:0] mv;
    logic [7:0]  mr;
    bit          ok;
    for (int it = 0; it < 6; it++) begin
      b = $urandom_range(5, 24);
      l = $urandom_range(1, 6);
      clear_results();
      for (int i = 0; i < l; i++) begin
        res_val[i] = $urandom_range(0, 40);
        res_of[i]  = ($urandom_range(0, 3) == 0);
        res_acc[i] = ($urandom_range(0, 3) == 0);
      end
      fill_mem(b, l);
      do_run(b, l, w);
      model_min(l, mv, mr, ok);
      n_chk++; if (done !== 1'b1 || mse_hsp_bands !== b[7:0])
        $display("FAIL rand%0d_done got done=%b bands=%0d exp 1/%0d", it, done, mse_hsp_bands, b); else n_pass++;
      n_chk++; if (stream_errors(b, l) != 0)
        $display("FAIL rand%0d_stream b=%0d l=%0d got %0d errors exp 0", it, b, l, stream_errors(b, l)); else n_pass++;
      n_chk++; if (min_mse_value !== mv || min_mse_ref !== mr || min_valid !== ok)
        $display("FAIL rand%0d_min got %0d ref %0d v %b exp %0d ref %0d v %b", it, min_mse_value, min_mse_ref, min_valid, mv, mr, ok); else n_pass++;
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    clear_results();
    for (int i = 0; i < 128; i++) pix_mem[i] = '0;
    test_reset();
    test_basic();
    test_odd();
    test_tie_overflow();
    test_error();
    test_back_to_back();
    test_abort();
    test_reset_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
